// File: rtl/hazard_control_unit.sv
// Stall/freeze/flush sequencer for the 5-stage pipeline: load-use, branch, multi-cycle MDU, dmem waits.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mdu_busy,
  output logic             mdu_error,
  output logic [CNT_W-1:0] perf_load_use,
  output logic [CNT_W-1:0] perf_mdu,
  output logic [CNT_W-1:0] perf_mem,
  output logic [CNT_W-1:0] perf_flush
);
  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] MDU_WAIT = 2'b01;
  localparam int         WC_W     = $clog2(MDU_TIMEOUT);

  logic [1:0]      state, state_nxt;
  logic [WC_W-1:0] wcnt, wcnt_nxt;
  logic            done_q, done_nxt;
  logic            mem_stall, load_use;
  logic            lu_stall, br_flush;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = id_ex_mem_read & (id_ex_rd != 5'd0) &
                     ((id_ex_rd == id_rs1) | (id_ex_rd == id_rs2));
  assign mdu_busy  = (state == MDU_WAIT);

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mdu_error    = 1'b0;
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    done_nxt     = done_q;
    lu_stall     = 1'b0;
    br_flush     = 1'b0;
    if (reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      {if_id_flush, id_ex_flush, ex_mem_flush}           = 3'b111;
    end else if (mem_stall) begin
      // Full freeze; a result landing now is remembered for the first unfrozen cycle.
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      if (state == MDU_WAIT && mdu_done) done_nxt = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_flush    = 1'b1;
            if (ex_mdu_start) begin
              state_nxt = MDU_WAIT;
              wcnt_nxt  = '0;
              done_nxt  = 1'b0;
            end
          end else if (ex_mdu_start) begin
            state_nxt = MDU_WAIT;
            wcnt_nxt  = '0;
            done_nxt  = 1'b0;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            lu_stall    = 1'b1;
          end
        end
        MDU_WAIT: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          if (mdu_done || done_q) begin
            ex_mem_flush = 1'b0;
            state_nxt    = RUN;
            done_nxt     = 1'b0;
          end else if (wcnt == WC_W'(MDU_TIMEOUT - 1)) begin
            mdu_error = 1'b1;
            state_nxt = RUN;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      wcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wcnt   <= wcnt_nxt;
      done_q <= done_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic mdu_cyc;
  assign mdu_cyc = (state == MDU_WAIT) & ~mem_stall;

  // A frozen cycle only ever counts as a memory stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_load_use <= '0;
      perf_mdu      <= '0;
      perf_mem      <= '0;
      perf_flush    <= '0;
    end else begin
      if (lu_stall  && !(&perf_load_use)) perf_load_use <= perf_load_use + CNT_W'(1);
      if (mdu_cyc   && !(&perf_mdu))      perf_mdu      <= perf_mdu + CNT_W'(1);
      if (mem_stall && !(&perf_mem))      perf_mem      <= perf_mem + CNT_W'(1);
      if (br_flush  && !(&perf_flush))    perf_flush    <= perf_flush + CNT_W'(1);
    end
  end
`else
  logic unused_perf;
  assign unused_perf   = lu_stall | br_flush;
  assign perf_load_use = '0;
  assign perf_mdu      = '0;
  assign perf_mem      = '0;
  assign perf_flush    = '0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (MDU_TIMEOUT=8); output vector checked every step.
module tb_hazard_control_unit;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic id_ex_mem_read, ex_branch_taken, ex_mdu_start, mdu_done, dmem_req, dmem_ready;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mdu_busy, mdu_error;
  logic [CNT_W-1:0] perf_load_use, perf_mdu, perf_mem, perf_flush;

  int checks = 0;
  int errors = 0;

  // {pc, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f, ex_mem_f, busy, err}
  localparam logic [8:0] DEF   = 9'b1111_000_00;
  localparam logic [8:0] RST   = 9'b0000_111_00;
  localparam logic [8:0] RST_M = 9'b0000_111_10;
  localparam logic [8:0] LU    = 9'b0011_010_00;
  localparam logic [8:0] BR    = 9'b1111_110_00;
  localparam logic [8:0] MW    = 9'b0001_001_10;
  localparam logic [8:0] MDONE = 9'b0001_000_10;
  localparam logic [8:0] MTO   = 9'b0001_001_11;
  localparam logic [8:0] FRZ_M = 9'b0000_000_10;
  localparam logic [8:0] FRZ_R = 9'b0000_000_00;

  hazard_control_unit #(.MDU_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mdu_busy(mdu_busy), .mdu_error(mdu_error),
    .perf_load_use(perf_load_use), .perf_mdu(perf_mdu),
    .perf_mem(perf_mem), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge, apply inputs, let them settle.
  task automatic step(input logic rst, input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic br,
                      input logic st, input logic dn, input logic rq, input logic rdy);
    @(posedge clk); #1;
    reset = rst; id_ex_mem_read = mr; id_ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
    ex_branch_taken = br; ex_mdu_start = st; mdu_done = dn; dmem_req = rq; dmem_ready = rdy;
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, ex_mem_flush, mdu_busy, mdu_error};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag, input int lu, input int md, input int mm, input int fl);
`ifdef HAZARD_PERF_EN
    chkp({tag, "_lu"},  perf_load_use, CNT_W'(lu));
    chkp({tag, "_mdu"}, perf_mdu,      CNT_W'(md));
    chkp({tag, "_mem"}, perf_mem,      CNT_W'(mm));
    chkp({tag, "_fl"},  perf_flush,    CNT_W'(fl));
`else
    chkp({tag, "_all"}, perf_load_use | perf_mdu | perf_mem | perf_flush,
         CNT_W'(lu & md & mm & fl & 0));
`endif
  endtask

  initial begin
    reset = 1'b1; id_ex_mem_read = 1'b0; id_ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;

    // Reset and idle
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("reset", RST);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("idle", DEF);
    chk_perf("perf_reset", 0, 0, 0, 0);

    // Load-use on rs1 and rs2, x0 and non-load cases
    step(0, 1, 5, 5, 0, 0, 0, 0, 0, 0); chk("lu_rs1", LU);
    step(0, 0, 5, 5, 0, 0, 0, 0, 0, 0); chk("lu_after", DEF);
    step(0, 1, 7, 1, 7, 0, 0, 0, 0, 0); chk("lu_rs2", LU);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); chk("lu_x0", DEF);
    step(0, 0, 5, 5, 0, 0, 0, 0, 0, 0); chk("no_load", DEF);

    // Branch beats load-use
    step(0, 1, 5, 5, 0, 1, 0, 0, 0, 0); chk("br_lu", BR);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("br_after", DEF);
    chk_perf("perf_br", 2, 0, 0, 1);

    // MDU: done five cycles after start; branch/load-use ignored while waiting
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); chk("mdu_start", DEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("mdu_w1", MW);
    step(0, 1, 5, 5, 0, 1, 0, 0, 0, 0); chk("mdu_w2_ign", MW);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("mdu_w3", MW);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("mdu_w4", MW);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); chk("mdu_done", MDONE);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("mdu_back", DEF);

    // Watchdog: 8th wait cycle aborts
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); chk("wd_start", DEF);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("wd_wait", MW);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("wd_abort", MTO);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); chk("done_in_run", DEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("wd_after", DEF);

    // Memory freeze inside MDU_WAIT with done arriving mid-freeze
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); chk("mf_start", DEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("mf_w1", MW);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); chk("mf_frz1", FRZ_M);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); chk("mf_frz2", FRZ_M);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); chk("mf_frz3", FRZ_M);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("mf_sticky", MDONE);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("mf_back", DEF);

    // Freeze in RUN overrides load-use; ready ends the stall
    step(0, 1, 5, 5, 0, 0, 0, 0, 1, 0); chk("frz_run", FRZ_R);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); chk("mem_ready", DEF);
    chk_perf("perf_total", 2, 15, 4, 1);

    // Branch with MDU start, then reset mid-wait
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0); chk("br_mdu", BR);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("br_mdu_w", MW);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("rst_mid", RST_M);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("rst_after", DEF);
    chk_perf("perf_cleared", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
